// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer type and
// Gray/binary conversions used by both the read and write pointer handlers.
package fifo_pkg;

    localparam int ADDR_SIZE = 8;

    typedef logic [ADDR_SIZE:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above its position.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary converter of configurable width,
// shared by the read and write pointer handlers.
module gray2bin_conv #(
    parameter int width_p = 9
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] bin_o
);

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < width_p; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/read_pointer_handler.sv
// Read-domain pointer logic of the async FIFO: binary/Gray read pointers, empty,
// level and almost-empty. Optional sticky underflow flag under RD_UNDERFLOW_EN.
module read_pointer_handler
    import fifo_pkg::*;
#(
    parameter int addr_size_p = ADDR_SIZE,
    parameter int ae_thresh_p = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rd_en,
    input  logic [addr_size_p:0] g_w_ptr_sync,
    output logic                 rd_fire,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [addr_size_p:0] rd_level,
    output logic [addr_size_p:0] b_r_ptr,
    output logic [addr_size_p:0] g_r_ptr
`ifdef RD_UNDERFLOW_EN
    ,
    output logic                 underflow
`endif
);

    localparam int PtrW = addr_size_p + 1;

    typedef logic [addr_size_p:0] rptr_t;

    localparam rptr_t PtrOne   = rptr_t'(1);
    localparam rptr_t AeThresh = rptr_t'(ae_thresh_p);

    rptr_t bRPtr_q;
    rptr_t bRPtr_d;
    rptr_t gRPtr_q;
    rptr_t gRPtr_d;
    rptr_t bWPtrSync;

    gray2bin_conv #(
        .width_p(PtrW)
    ) u_wPtrConv (
        .gray_i(g_w_ptr_sync),
        .bin_o (bWPtrSync)
    );

    assign empty        = (bWPtrSync == bRPtr_q);
    assign rd_fire      = rd_en & ~empty;
    assign rd_level     = bWPtrSync - bRPtr_q;
    assign almost_empty = (rd_level <= AeThresh);

    // Gray is derived from the next binary value so the registered Gray
    // pointer never glitches on its way to the write-domain synchronizer.
    always_comb begin
        bRPtr_d = bRPtr_q;
        if (rd_fire) begin
            bRPtr_d = bRPtr_q + PtrOne;
        end
        gRPtr_d = (bRPtr_d >> 1) ^ bRPtr_d;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            bRPtr_q <= '0;
            gRPtr_q <= '0;
        end else begin
            bRPtr_q <= bRPtr_d;
            gRPtr_q <= gRPtr_d;
        end
    end

    assign b_r_ptr = bRPtr_q;
    assign g_r_ptr = gRPtr_q;

`ifdef RD_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow_q <= 1'b0;
        end else if (rd_en & empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_read_pointer_handler.sv
// Self-checking bench for read_pointer_handler (addr_size_p=3, ae_thresh_p=2),
// table vectors plus hand sequences, expected values queued in a scoreboard.
module tb_read_pointer_handler;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rd_en;
    logic [3:0] g_w_ptr_sync;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic [3:0] b_r_ptr;
    logic [3:0] g_r_ptr;
`ifdef RD_UNDERFLOW_EN
    logic       underflow;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       rdEn;
        logic [3:0] gw;
        logic       fire;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic [3:0] bPtr;
        logic [3:0] gPtr;
    } vector_t;

    typedef struct {
        int         id;
        logic       fire;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic [3:0] bPtr;
        logic [3:0] gPtr;
    } expect_t;

    expect_t scoreboard[$];
    vector_t tbl[12];

    read_pointer_handler #(
        .addr_size_p(3),
        .ae_thresh_p(2)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .rd_en       (rd_en),
        .g_w_ptr_sync(g_w_ptr_sync),
        .rd_fire     (rd_fire),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_level    (rd_level),
        .b_r_ptr     (b_r_ptr),
        .g_r_ptr     (g_r_ptr)
`ifdef RD_UNDERFLOW_EN
        ,
        .underflow   (underflow)
`endif
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic expect_t mkExp(input int id, input logic f, input logic e,
                                      input logic a, input logic [3:0] l,
                                      input logic [3:0] b, input logic [3:0] g);
        expect_t x;
        x.id = id; x.fire = f; x.empty = e; x.ae = a;
        x.level = l; x.bPtr = b; x.gPtr = g;
        return x;
    endfunction

    task automatic expectEq(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Drive one cycle's inputs just after the edge and queue what they should produce.
    task automatic applyStimulus(input logic rd, input logic [3:0] gw, input expect_t e);
        @(posedge rclk);
        #1;
        rd_en        = rd;
        g_w_ptr_sync = gw;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        @(negedge rclk);
        if (scoreboard.size() == 0) begin
            expectEq("scoreboard.empty", 0, 1);
        end else begin
            e = scoreboard.pop_front();
            expectEq($sformatf("v%0d.rd_fire", e.id), int'(rd_fire), int'(e.fire));
            expectEq($sformatf("v%0d.empty", e.id), int'(empty), int'(e.empty));
            expectEq($sformatf("v%0d.almost_empty", e.id), int'(almost_empty), int'(e.ae));
            expectEq($sformatf("v%0d.rd_level", e.id), int'(rd_level), int'(e.level));
            expectEq($sformatf("v%0d.b_r_ptr", e.id), int'(b_r_ptr), int'(e.bPtr));
            expectEq($sformatf("v%0d.g_r_ptr", e.id), int'(g_r_ptr), int'(e.gPtr));
        end
    endtask

    initial begin
        logic [3:0] wb;
        logic [3:0] mb;
        logic [3:0] lvl;
        logic [3:0] prevG;
        logic       rd;
        logic       f;
        int         reads;
        int         wrapSeen;

        // rdEn, gw, fire, empty, ae, level, b, g
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd4, 4'd1, 4'b0001};
        tbl[6]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2, 4'b0011};
        tbl[7]  = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 4'b0010};
        tbl[8]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 4'b0010};
        tbl[9]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 4'd1, 4'd4, 4'b0110};
        tbl[10] = '{1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'b0111};
        tbl[11] = '{1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'b0111};

        rrst_n       = 1'b0;
        rd_en        = 1'b0;
        g_w_ptr_sync = 4'b0000;
        #2;
        expectEq("reset.b_r_ptr", int'(b_r_ptr), 0);
        expectEq("reset.g_r_ptr", int'(g_r_ptr), 0);
        expectEq("reset.empty", int'(empty), 1);
        expectEq("reset.rd_level", int'(rd_level), 0);
        expectEq("reset.almost_empty", int'(almost_empty), 1);
        expectEq("reset.rd_fire", int'(rd_fire), 0);
`ifdef RD_UNDERFLOW_EN
        expectEq("reset.underflow", int'(underflow), 0);
`endif
        @(negedge rclk);
        rrst_n = 1'b1;

        // Read-while-empty, then fill to five words and drain them.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].rdEn, tbl[i].gw,
                          mkExp(i, tbl[i].fire, tbl[i].empty, tbl[i].ae,
                                tbl[i].level, tbl[i].bPtr, tbl[i].gPtr));
            checkOutput();
        end
`ifdef RD_UNDERFLOW_EN
        expectEq("underflow.sticky", int'(underflow), 1);
`endif

        // Reset asserted while reads are in flight.
        applyStimulus(1'b1, 4'b1100, mkExp(100, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 4'b0111));
        checkOutput();
        applyStimulus(1'b1, 4'b1100, mkExp(101, 1'b1, 1'b0, 1'b1, 4'd2, 4'd6, 4'b0101));
        checkOutput();
        @(posedge rclk);
        #1;
        expectEq("midread.b_r_ptr_before", int'(b_r_ptr), 7);
        #1;
        rrst_n = 1'b0;
        #1;
        expectEq("midread.b_r_ptr_cleared", int'(b_r_ptr), 0);
        expectEq("midread.g_r_ptr_cleared", int'(g_r_ptr), 0);
        expectEq("midread.rd_level_full", int'(rd_level), 8);
        rd_en        = 1'b0;
        g_w_ptr_sync = 4'b0000;
        #1;
        expectEq("midread.empty", int'(empty), 1);
        expectEq("midread.rd_level", int'(rd_level), 0);
        expectEq("midread.almost_empty", int'(almost_empty), 1);
`ifdef RD_UNDERFLOW_EN
        expectEq("midread.underflow_cleared", int'(underflow), 0);
`endif
        @(negedge rclk);
        rrst_n = 1'b1;

        // Full from the read side: MSBs differ, low bits equal.
        applyStimulus(1'b0, 4'b1100, mkExp(200, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'b0000));
        checkOutput();

        // Random-paced writes and reads across the pointer wrap.
        wb       = 4'd8;
        mb       = 4'd0;
        prevG    = 4'b0000;
        reads    = 0;
        wrapSeen = 0;
        for (int cyc = 0; cyc < 400 && reads < 40; cyc++) begin
            lvl = wb - mb;
            if ($urandom_range(0, 1) == 1 && lvl < 4'd8) wb = wb + 4'd1;
            rd  = ($urandom_range(0, 3) != 0);
            lvl = wb - mb;
            f   = rd & (lvl != 4'd0);
            applyStimulus(rd, gray4(wb),
                          mkExp(300 + cyc, f, lvl == 4'd0, lvl <= 4'd2, lvl, mb, gray4(mb)));
            checkOutput();
            if (g_r_ptr != prevG) begin
                expectEq($sformatf("gray.onebit%0d", cyc), $countones(g_r_ptr ^ prevG), 1);
            end
            if (prevG == 4'b1000 && g_r_ptr == 4'b0000) wrapSeen = 1;
            prevG = g_r_ptr;
            if (f) begin
                mb    = mb + 4'd1;
                reads = reads + 1;
            end
        end
        expectEq("wrap.g1000to0000", wrapSeen, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/read_pointer_handler.md
# read_pointer_handler

Read-side pointer logic of the asynchronous FIFO, in the read clock domain. Keeps the binary and Gray read pointers and converts the synchronized Gray write pointer back to binary. Produces empty, occupancy level, almost-empty and the memory read strobe. Its Gray pointer goes to the write-domain 2-FF synchronizer. It is the read-end counterpart of the write pointer handler that produces full.

## Interface
Parameters:
- addr_size_p, 8, memory address width; pointers are addr_size_p+1 bits (extra wrap bit).
- ae_thresh_p, 2, almost_empty asserts when rd_level <= ae_thresh_p.

Ports:
- rclk  input  1  read clock; one clock, all logic on its rising edge.
- rrst_n  input  1  asynchronous active-low reset.
- rd_en  input  1  read request.
- g_w_ptr_sync  input  addr_size_p+1  Gray write pointer, already 2-FF synchronized into rclk.
- rd_fire  output  1  rd_en & ~empty; memory read enable.
- empty  output  1  FIFO empty.
- almost_empty  output  1  rd_level <= ae_thresh_p.
- rd_level  output  addr_size_p+1  words available, 0..2^addr_size_p.
- b_r_ptr  output  addr_size_p+1  binary read pointer; low addr_size_p bits form the memory read address.
- g_r_ptr  output  addr_size_p+1  Gray read pointer, registered; sent to the write-domain synchronizer.
- underflow  output  1  sticky underflow error; present only with RD_UNDERFLOW_EN.

## Operation
- Pointer updates:
  - b_r_ptr increments by 1 on each rclk edge where rd_fire=1. It wraps modulo 2^(addr_size_p+1).
  - g_r_ptr is registered on the same edge as (b_next>>1)^b_next, where b_next is the next binary value. g_r_ptr always equals Gray(b_r_ptr), so no combinational glitches reach the CDC path.
- Write-pointer conversion: b_w_ptr_sync is combinational Gray-to-binary, MSB first: bit[n] = g[n]; bit[i] = bit[i+1]^g[i].
- empty = (b_w_ptr_sync == b_r_ptr), all addr_size_p+1 bits. Combinational.
- rd_level = b_w_ptr_sync - b_r_ptr, computed modulo 2^(addr_size_p+1). It is never above 2^addr_size_p for legal synchronized inputs.
- almost_empty is combinational from rd_level. It implies nothing about empty beyond rd_level==0 ⇒ empty.
- A read request while empty is ignored: the pointer holds and rd_fire=0.
- Wrap-around: when the MSB differs and the low bits are equal, the FIFO is full from the read view, rd_level = 2^addr_size_p and empty=0.
- Reset mid-operation: all registers clear immediately and asynchronously, and the outputs take their reset values within the same cycle.

## Timing
- Reset values: b_r_ptr=0, g_r_ptr=0, underflow=0. With g_w_ptr_sync=0: empty=1, rd_level=0, almost_empty=1, rd_fire=0.
- Reset release is synchronous to rclk; the first increment is possible on the first rising edge after rrst_n goes high.
- rd_fire, empty, rd_level and almost_empty are combinational, valid in the same cycle.
- The pointer update appears one rclk edge after rd_fire.
- Read data from memory is addressed by the current b_r_ptr; the data-latency policy belongs to the memory block.
- Empty deassert latency after a write: 2 rclk edges of synchronizer (external) plus 0 cycles here.
- Empty asserts on the edge that consumes the last word. Empty is pessimistic (may lag writes), never optimistic.
- A write landing in the synchronizer and a read on the same edge: the read uses the old synchronized value; the new value is seen the next cycle.

## Configuration
- RD_UNDERFLOW_EN defined:
  - underflow port exists.
  - It sets on any rclk edge with rd_en=1 & empty=1 and holds until rrst_n is asserted.
- Not defined: the port and flop are absent, and underflowing requests are silently dropped as above.

## Structure
- Shared package fifo_pkg:
  - ADDR_SIZE default constant.
  - ptr_t typedef (addr_size_p+1 bits).
  - bin2gray and gray2bin functions, also used by the write pointer handler.
- One natural sub-module: gray2bin_conv, parameterized width, purely combinational. It is shared with the write side.

## Test plan
All scenarios use addr_size_p=3 and ae_thresh_p=2.
- Reset: hold rrst_n=0 with g_w_ptr_sync=0 → b_r_ptr=0, g_r_ptr=0, empty=1, rd_level=0, almost_empty=1. Assert rrst_n mid-read → pointers clear immediately.
- Read while empty: g_w_ptr_sync=0, rd_en=1 for 3 cycles → rd_fire=0, b_r_ptr stays 0. With RD_UNDERFLOW_EN, underflow=1 and stays 1 until reset.
- Fill then drain: g_w_ptr_sync=Gray(5)=4'b0111 → rd_level=5, empty=0, almost_empty=0. Read 3 → rd_level=2, almost_empty=1. Read 2 more → empty=1, b_r_ptr=5, g_r_ptr=4'b0111.
- Full view: b_r_ptr=0, g_w_ptr_sync=Gray(8)=4'b1100 → rd_level=8, empty=0.
- Wrap: step read and write pointers through 15→0 → g_r_ptr sequence 1000→0000, rd_level correct across the wrap, empty when equal.
- Gray check: over 40 random-paced reads, every g_r_ptr change flips exactly one bit and equals Gray(b_r_ptr) every cycle.
